apb_timer_slave: RTL and testbench

// - APB slave peripheral sitting directly downstream of the AHB-to-APB bridge on the APB side.
// - Consumes the bridge's psel/penable/pwrite/paddr/pwdata.
// - Returns prdata/pready/pslverr.
// - Exposes a programmable down-counting timer: 4 memory-mapped registers, programmable wait states, irq.

---
 rtl/apb_timer_slave.sv | 150 +++++++++++++++
 tb/tb_apb_timer_slave.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave.sv
// APB slave with a programmable down-counting timer, four registers and irq.
// Ports: hclk/hreset, APB psel/penable/pwrite/paddr/pwdata in, prdata/pready/pslverr out, irq out.
`timescale 1ns/1ps
module apb_timer_slave #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              irq
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_e;

   localparam logic [3:0] WAIT_V = 4'(WAIT_CYCLES);

   state_e            state_q;
   logic [3:0]        wait_cnt_q;
   logic [2:0]        ctrl_q, ctrl_d;
   logic [DATA_W-1:0] load_q, load_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic              expired_q, expired_d;
   logic              irq_q;

   logic              addr_ok;
   logic [1:0]        idx;
   logic              err;
   logic              ready;
   logic              wr_en;
   logic              expire;
   logic [DATA_W-1:0] rd_val;

   assign addr_ok = (paddr[ADDR_W-1:4] == '0) && (paddr[1:0] == 2'b00);
   assign idx     = paddr[3:2];
   assign err     = !addr_ok || (pwrite && idx == 2'd2);

   // SETUP is the first penable cycle and counts as wait slot 0, so the
   // access phase lasts WAIT_CYCLES+1 cycles.
   assign ready = (state_q == SETUP || state_q == ACCESS)
                  && psel && penable && (wait_cnt_q == WAIT_V);

   assign wr_en   = ready && pwrite && !err;
   assign pready  = ready;
   assign pslverr = ready && err;
   assign irq     = irq_q;

   always_comb begin
      rd_val = '0;
      case (idx)
         2'd0:    rd_val = {{(DATA_W-3){1'b0}}, ctrl_q};
         2'd1:    rd_val = load_q;
         2'd2:    rd_val = count_q;
         default: rd_val = {{(DATA_W-1){1'b0}}, expired_q};
      endcase
   end

   assign prdata = (ready && !pwrite && !err) ? rd_val : '0;

   always_comb begin
      ctrl_d    = ctrl_q;
      load_d    = load_q;
      count_d   = count_q;
      expired_d = expired_q;
      expire    = 1'b0;
      if (ctrl_q[0]) begin
         if (count_q != '0) begin
            count_d = count_q - DATA_W'(1);
         end else begin
            expire = 1'b1;
            if (ctrl_q[1]) count_d = load_q;
            else           ctrl_d[0] = 1'b0;
         end
      end
      if (wr_en) begin
         case (idx)
            2'd0: begin
               ctrl_d = pwdata[2:0];
               // disabling write freezes COUNT, suppressing any reload
               if (!pwdata[0]) count_d = count_q;
            end
            2'd1: begin
               load_d  = pwdata;
               count_d = pwdata;
            end
            2'd3: if (pwdata[0]) expired_d = 1'b0;
            default: ;
         endcase
      end
      // a fresh expiry beats a same-edge W1C
      if (expire) expired_d = 1'b1;
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         ctrl_q     <= '0;
         load_q     <= '0;
         count_q    <= '0;
         expired_q  <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         count_q   <= count_d;
         expired_q <= expired_d;
         irq_q     <= expired_q & ctrl_q[2];
         unique case (state_q)
            IDLE: begin
               if (psel && !penable) begin
                  state_q    <= SETUP;
                  wait_cnt_q <= '0;
               end
            end
            SETUP, ACCESS: begin
               // ready implies penable, so a completed transfer returns
               // to IDLE and the next setup cycle re-enters SETUP
               if (!psel || ready) begin
                  state_q    <= IDLE;
                  wait_cnt_q <= '0;
               end else if (penable) begin
                  state_q    <= ACCESS;
                  wait_cnt_q <= wait_cnt_q + 4'd1;
               end else begin
                  state_q    <= SETUP;
                  wait_cnt_q <= '0;
               end
            end
            default: begin
               state_q    <= IDLE;
               wait_cnt_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave with a queue-based response scoreboard.
// Ports: drives the APB side and checks prdata/pready/pslverr/irq.
`timescale 1ns/1ps
module tb_apb_timer_slave;

   logic        hclk = 1'b0;
   logic        hreset = 1'b1;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [7:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        irq;

   always #5 hclk = ~hclk;

   apb_timer_slave #(
      .ADDR_W(8),
      .DATA_W(32),
      .WAIT_CYCLES(1)
   ) dut (
      .hclk(hclk),
      .hreset(hreset),
      .psel(psel),
      .penable(penable),
      .pwrite(pwrite),
      .paddr(paddr),
      .pwdata(pwdata),
      .prdata(prdata),
      .pready(pready),
      .pslverr(pslverr),
      .irq(irq)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       nm;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   // scoreboard monitor: every completed transfer pops one expectation
   always @(negedge hclk) begin
      exp_t e;
      if (!hreset && psel && penable && pready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_pready: got 1 want 0 (addr 0x%02h)",
                     paddr);
         end else begin
            e = exp_q.pop_front();
            chk({e.nm, "/prdata"}, prdata, e.rdata);
            chk({e.nm, "/pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
         end
      end
   end

   // leaves psel high and penable low so a following call is back-to-back
   task automatic xfer(input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [31:0] er,
                       input logic ee, input string nm);
      int   low;
      exp_t e;
      e.rdata = er;
      e.err   = ee;
      e.nm    = nm;
      exp_q.push_back(e);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = w;
      paddr   = a;
      pwdata  = d;
      @(posedge hclk);
      #1 penable = 1'b1;
      low = 0;
      do begin
         @(negedge hclk);
         if (!pready) low++;
      end while (!pready && low <= 40);
      if (!pready) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s/timeout: got pready 0 want 1", nm);
         exp_q.delete(exp_q.size() - 1);
      end else begin
         chk({nm, "/wait"}, 32'(low), 32'd1);
      end
      @(posedge hclk);
      #1 penable = 1'b0;
   endtask

   task automatic idle(input int n);
      psel    = 1'b0;
      penable = 1'b0;
      repeat (n) begin
         @(posedge hclk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      // power-on reset
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      chk("rst/pready", {31'b0, pready}, 32'd0);
      chk("rst/prdata", prdata, 32'd0);
      chk("rst/pslverr", {31'b0, pslverr}, 32'd0);
      chk("rst/irq", {31'b0, irq}, 32'd0);
      hreset = 1'b0;
      @(posedge hclk);
      #1;

      // one-shot, LOAD=5: expiry lands 6 edges after the CTRL write
      xfer(1, 8'h04, 32'd5, 32'd0, 0, "osA/wload");
      idle(1);
      xfer(1, 8'h00, 32'd1, 32'd0, 0, "osA/wctrl");
      xfer(0, 8'h08, 32'd0, 32'd3, 0, "osA/count+2");
      xfer(0, 8'h0C, 32'd0, 32'd0, 0, "osA/status+5");
      xfer(0, 8'h0C, 32'd0, 32'd1, 0, "osA/status+8");
      xfer(0, 8'h00, 32'd0, 32'd0, 0, "osA/en_clear");
      xfer(0, 8'h08, 32'd0, 32'd0, 0, "osA/count_hold");
      idle(1);

      xfer(1, 8'h0C, 32'd1, 32'd0, 0, "osB/w1c");
      idle(1);
      xfer(1, 8'h04, 32'd5, 32'd0, 0, "osB/wload");
      idle(1);
      xfer(1, 8'h00, 32'd1, 32'd0, 0, "osB/wctrl");
      idle(4);
      xfer(0, 8'h0C, 32'd0, 32'd1, 0, "osB/status+6");
      idle(1);

      // auto-reload with irq, LOAD=2
      xfer(1, 8'h0C, 32'd1, 32'd0, 0, "ar/w1c");
      idle(1);
      xfer(1, 8'h04, 32'd2, 32'd0, 0, "ar/wload");
      idle(1);
      xfer(1, 8'h00, 32'd7, 32'd0, 0, "ar/wctrl");
      psel    = 1'b0;
      penable = 1'b0;
      for (int j = 0; j < 6; j++) begin
         @(negedge hclk);
         chk($sformatf("ar/irq+%0d", j), {31'b0, irq},
             (j >= 4) ? 32'd1 : 32'd0);
         @(posedge hclk);
         #1;
      end
      xfer(0, 8'h08, 32'd0, 32'd0, 0, "ar/count+8");
      idle(1);
      xfer(0, 8'h08, 32'd0, 32'd2, 0, "ar/count+12");
      idle(1);
      xfer(0, 8'h08, 32'd0, 32'd1, 0, "ar/count+16");
      idle(1);

      // stop, then W1C drops irq one cycle later
      xfer(1, 8'h00, 32'd6, 32'd0, 0, "w1c/wctrl");
      idle(1);
      xfer(1, 8'h0C, 32'd1, 32'd0, 0, "w1c/wstatus");
      psel    = 1'b0;
      penable = 1'b0;
      @(negedge hclk);
      chk("w1c/irq_lag", {31'b0, irq}, 32'd1);
      @(posedge hclk);
      #1;
      @(negedge hclk);
      chk("w1c/irq_drop", {31'b0, irq}, 32'd0);
      @(posedge hclk);
      #1;
      xfer(0, 8'h0C, 32'd0, 32'd0, 0, "w1c/status");
      idle(1);

      // W1C commits on the same edge as an expiry
      xfer(1, 8'h04, 32'd2, 32'd0, 0, "sw/wload");
      idle(1);
      xfer(1, 8'h00, 32'd7, 32'd0, 0, "sw/wctrl");
      xfer(1, 8'h0C, 32'd1, 32'd0, 0, "sw/wstatus");
      xfer(0, 8'h0C, 32'd0, 32'd1, 0, "sw/status");
      idle(1);

      // error responses leave registers alone
      xfer(1, 8'h00, 32'd4, 32'd0, 0, "err/wctrl");
      idle(1);
      xfer(1, 8'h04, 32'h1234, 32'd0, 0, "err/wload");
      idle(1);
      xfer(1, 8'h08, 32'hFFFF, 32'd0, 1, "err/wcount");
      idle(1);
      xfer(0, 8'h08, 32'd0, 32'h1234, 0, "err/count");
      xfer(0, 8'h10, 32'd0, 32'd0, 1, "err/r10");
      xfer(0, 8'h06, 32'd0, 32'd0, 1, "err/r06");
      xfer(1, 8'h14, 32'd7, 32'd0, 1, "err/w14");
      xfer(0, 8'h00, 32'd0, 32'd4, 0, "err/ctrl");
      xfer(0, 8'h04, 32'd0, 32'h1234, 0, "err/load");
      idle(1);

      // back-to-back write then read
      xfer(1, 8'h04, 32'hA5A5_0001, 32'd0, 0, "b2b/wload");
      xfer(0, 8'h04, 32'd0, 32'hA5A5_0001, 0, "b2b/rload");
      idle(1);

      // psel dropped before pready
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'h04;
      pwdata  = 32'hDEAD_BEEF;
      @(posedge hclk);
      #1 penable = 1'b1;
      @(posedge hclk);
      #1;
      idle(1);
      xfer(0, 8'h04, 32'd0, 32'hA5A5_0001, 0, "abort/rload");
      idle(1);

      // reset in the middle of a LOAD write
      @(negedge hclk);
      chk("rst2/irq_pre", {31'b0, irq}, 32'd1);
      @(posedge hclk);
      #1;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'h04;
      pwdata  = 32'h55;
      @(posedge hclk);
      #1;
      penable = 1'b1;
      hreset  = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(posedge hclk);
         @(negedge hclk);
         chk($sformatf("rst2/pready%0d", j), {31'b0, pready}, 32'd0);
         chk($sformatf("rst2/prdata%0d", j), prdata, 32'd0);
         chk($sformatf("rst2/pslverr%0d", j), {31'b0, pslverr}, 32'd0);
         chk($sformatf("rst2/irq%0d", j), {31'b0, irq}, 32'd0);
      end
      hreset  = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge hclk);
      #1;
      xfer(0, 8'h04, 32'd0, 32'd0, 0, "rst2/load");
      xfer(0, 8'h00, 32'd0, 32'd0, 0, "rst2/ctrl");
      xfer(0, 8'h0C, 32'd0, 32'd0, 0, "rst2/status");
      idle(2);

      chk("sb/left", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
